// File: rtl/axi_rd_arbiter_2to1_pkg.sv
// Shared constants, state encoding and arbitration helper for the 2:1 AXI read arbiter.
// Port IDs double as the LSB of ARID/RID.
package axi_rd_arbiter_2to1_pkg;

  localparam logic ID_I = 1'b0;
  localparam logic ID_D = 1'b1;

  // Enough for MAX_OUTSTANDING up to 7
  localparam int CNT_W = 3;

  localparam logic [2:0] AR_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AR_BURST_INCR = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADDR = 1'b1
  } arb_state_e;

  // Choose a port among the eligible ones; only meaningful when at least one is eligible.
  function automatic logic arb_pick(input logic elig_i,
                                    input logic elig_d,
                                    input logic d_prio,
                                    input logic last_grant);
    logic pick;
    if (elig_i && !elig_d) begin
      pick = ID_I;
    end else if (elig_d && !elig_i) begin
      pick = ID_D;
    end else if (d_prio) begin
      pick = ID_D;
    end else begin
      pick = ~last_grant;
    end
    return pick;
  endfunction

  function automatic logic [3:0] make_arid(input logic port);
    return {3'b000, port};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_2to1_outstanding_ctr.sv
// Per-port outstanding-burst counter: gated increment, decrement blocked at zero,
// and a sticky flag for a burst completion that had nothing outstanding.
module axi_rd_arbiter_2to1_outstanding_ctr
  import axi_rd_arbiter_2to1_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic             M_AXI_ACLK,
  input  logic             M_AXI_ARESETN,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             can_inc,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

  logic             inc_ok;
  logic             dec_ok;
  logic             dec_blocked;
  logic [CNT_W-1:0] count_nxt;

  assign can_inc = (count < MAX_C);

  always_comb begin
    inc_ok      = inc & can_inc;
    dec_ok      = dec & (count != '0);
    dec_blocked = dec & (count == '0);
    count_nxt   = count;
    if (inc_ok && !dec_ok) begin
      count_nxt = count + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= count_nxt;
      if (dec_blocked) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_rd_arbiter_2to1.sv
// Shares one AXI read master between instruction fetch (I) and data-cache miss (D) ports.
// One AR in flight at a time; R beats are steered back combinationally by RID[0].
//
// state   | meaning
// ST_IDLE | no AR pending; may grant one eligible requester this cycle
// ST_ADDR | registered AR presented on M_AXI_AR*, waiting for ARREADY
module axi_rd_arbiter_2to1
  import axi_rd_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int D_PRIORITY      = 1
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,

  input  logic [ADDR_W-1:0] i_araddr,
  input  logic [7:0]        i_arlen,
  input  logic              i_arvalid,
  output logic              i_arready,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rlast,
  output logic              i_rvalid,
  input  logic              i_rready,

  input  logic [ADDR_W-1:0] d_araddr,
  input  logic [7:0]        d_arlen,
  input  logic              d_arvalid,
  output logic              d_arready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rlast,
  output logic              d_rvalid,
  input  logic              d_rready,

  output logic [3:0]        M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,

  input  logic [3:0]        M_AXI_RID,
  input  logic [DATA_W-1:0] M_AXI_RDATA,
  input  logic              M_AXI_RLAST,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY,

  output logic              err_unexpected_r,
  output logic              idle
);

  localparam logic D_PRIO = (D_PRIORITY != 0);

  arb_state_e        state_q;
  arb_state_e        state_nxt;
  logic              last_grant_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [3:0]        arid_q;

  logic              elig_i;
  logic              elig_d;
  logic              grant_vld;
  logic              grant_port;

  logic              i_can_inc;
  logic              d_can_inc;
  logic              i_dec;
  logic              d_dec;
  logic [CNT_W-1:0]  i_count;
  logic [CNT_W-1:0]  d_count;
  logic              i_err;
  logic              d_err;

  logic              r_to_d;
  logic              unused_rid_hi;

  assign elig_i = i_arvalid & i_can_inc;
  assign elig_d = d_arvalid & d_can_inc;

  // Grants are only issued out of reset so arready stays low while reset is held
  always_comb begin
    grant_vld  = (state_q == ST_IDLE) && M_AXI_ARESETN && (elig_i || elig_d);
    grant_port = arb_pick(elig_i, elig_d, D_PRIO, last_grant_q);
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (grant_vld)     state_nxt = ST_ADDR;
      ST_ADDR: if (M_AXI_ARREADY) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    i_arready     = grant_vld && (grant_port == ID_I);
    d_arready     = grant_vld && (grant_port == ID_D);
    M_AXI_ARVALID = (state_q == ST_ADDR);
    idle          = (state_q == ST_IDLE) && (i_count == '0) && (d_count == '0);
  end

  // Last-grant resets to D so I wins the first round-robin tie
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      araddr_q     <= '0;
      arlen_q      <= '0;
      arid_q       <= '0;
      last_grant_q <= ID_D;
    end else if (grant_vld) begin
      araddr_q     <= (grant_port == ID_D) ? d_araddr : i_araddr;
      arlen_q      <= (grant_port == ID_D) ? d_arlen  : i_arlen;
      arid_q       <= make_arid(grant_port);
      last_grant_q <= grant_port;
    end
  end

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = arlen_q;
  assign M_AXI_ARID    = arid_q;
  assign M_AXI_ARSIZE  = AR_SIZE_WORD;
  assign M_AXI_ARBURST = AR_BURST_INCR;

  // Only RID[0] carries the owner; the upper bits are whatever the fabric returns
  assign r_to_d        = M_AXI_RID[0];
  assign unused_rid_hi = ^M_AXI_RID[3:1];

  always_comb begin
    i_rdata      = M_AXI_RDATA;
    d_rdata      = M_AXI_RDATA;
    i_rlast      = M_AXI_RLAST;
    d_rlast      = M_AXI_RLAST;
    i_rvalid     = M_AXI_RVALID && (r_to_d == ID_I);
    d_rvalid     = M_AXI_RVALID && (r_to_d == ID_D);
    M_AXI_RREADY = (r_to_d == ID_D) ? d_rready : i_rready;
  end

  assign i_dec = i_rvalid & i_rready & M_AXI_RLAST;
  assign d_dec = d_rvalid & d_rready & M_AXI_RLAST;

  axi_rd_arbiter_2to1_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ctr_i (
    .M_AXI_ACLK    (M_AXI_ACLK),
    .M_AXI_ARESETN (M_AXI_ARESETN),
    .inc           (i_arready),
    .dec           (i_dec),
    .count         (i_count),
    .can_inc       (i_can_inc),
    .err           (i_err)
  );

  axi_rd_arbiter_2to1_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_ctr_d (
    .M_AXI_ACLK    (M_AXI_ACLK),
    .M_AXI_ARESETN (M_AXI_ARESETN),
    .inc           (d_arready),
    .dec           (d_dec),
    .count         (d_count),
    .can_inc       (d_can_inc),
    .err           (d_err)
  );

  assign err_unexpected_r = i_err | d_err;

endmodule
